eeprom_responder: RTL and testbench

- Synthesizable responder (slave) for the proprietary 3-wire EEPROM bus: SS, SCLK and MOSI in, MISO out.
- Emulates the EEPROM end of the link so the MITM top level can be exercised in hardware and on the bench without a real part.
- Frame format: 20 bits, MSB first. 3-bit opcode, then 9-bit address, then 8-bit data. Read opcode is 3'b110, write opcode is 3'b101.
- Stores writes in an internal 512x8 array and answers reads on MISO.

---
 rtl/eeprom_bus_pkg.sv | 21 ++
 rtl/eeprom_responder_if.sv | 31 +++
 rtl/bus_input_sync.sv | 31 +++
 rtl/eeprom_responder.sv | 189 ++++++++++++++++++
 tb/tb_eeprom_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_bus_pkg.sv
// Shared definitions for the 3-wire EEPROM bus: field widths, opcodes and responder FSM encoding.
// Also imported by the MITM top level so both ends agree on the frame layout.
package eeprom_bus_pkg;

    localparam int OPCODE_W   = 3;
    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = OPCODE_W + ADDR_W + DATA_W;

    localparam logic [OPCODE_W-1:0] OP_READ  = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_WRITE = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WAIT_SS = 3'd4
    } state_t;

endpackage

// File: rtl/eeprom_responder_if.sv
// Bus pins and status outputs of eeprom_responder; wp_in exists only with
// EEPROM_RESPONDER_WRITE_PROTECT_EN defined.
interface eeprom_responder_if
    import eeprom_bus_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_W
);
    logic                 ss_in;
    logic                 sclk_in;
    logic                 mosi_in;
    logic                 miso_out;
    logic                 busy;
    logic                 frame_done;
    logic                 cmd_err;
    logic [ADDR_BITS-1:0] last_addr;

`ifdef EEPROM_RESPONDER_WRITE_PROTECT_EN
    logic                 wp_in;

    modport slave  (input  ss_in, sclk_in, mosi_in, wp_in,
                    output miso_out, busy, frame_done, cmd_err, last_addr);
    modport master (output ss_in, sclk_in, mosi_in, wp_in,
                    input  miso_out, busy, frame_done, cmd_err, last_addr);
`else
    modport slave  (input  ss_in, sclk_in, mosi_in,
                    output miso_out, busy, frame_done, cmd_err, last_addr);
    modport master (output ss_in, sclk_in, mosi_in,
                    input  miso_out, busy, frame_done, cmd_err, last_addr);
`endif

endinterface

// File: rtl/bus_input_sync.sv
// Multi-stage synchronizer for one asynchronous pin plus rise/fall detect.
// Level appears SYNC_STAGES cycles after the pin; edge pulses are one cycle wide.
module bus_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/eeprom_responder.sv
// EEPROM-side responder for the 3-wire bus with a 512x8 store; pin edges act SYNC_STAGES+1 cycles late.
// Write protect input is present only when EEPROM_RESPONDER_WRITE_PROTECT_EN is defined.
module eeprom_responder
    import eeprom_bus_pkg::*;
#(
    parameter int OPCODE_BITS = OPCODE_W,
    parameter int ADDR_BITS   = ADDR_W,
    parameter int DATA_BITS   = DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               sys_clk,
    input  logic               rst,
    eeprom_responder_if.slave  bus
);

    localparam int FRAME = OPCODE_BITS + ADDR_BITS + DATA_BITS;
    localparam int HDR   = OPCODE_BITS + ADDR_BITS;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0]       HDR_LAST   = CNT_W'(HDR - 1);
    localparam logic [CNT_W-1:0]       FRAME_LAST = CNT_W'(FRAME - 1);
    localparam logic [OPCODE_BITS-1:0] L_OP_READ  = OPCODE_BITS'(OP_READ);
    localparam logic [OPCODE_BITS-1:0] L_OP_WRITE = OPCODE_BITS'(OP_WRITE);

    logic w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall, w_mosi_lvl, w_wp_lvl;
    logic w_unused_ss_lvl, w_unused_sclk_lvl, w_unused_mosi_rise, w_unused_mosi_fall;

    bus_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .i_clk(sys_clk), .i_rst(rst), .i_async(bus.ss_in),
        .o_level(w_unused_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall));

    bus_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk(sys_clk), .i_rst(rst), .i_async(bus.sclk_in),
        .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

    bus_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .i_clk(sys_clk), .i_rst(rst), .i_async(bus.mosi_in),
        .o_level(w_mosi_lvl), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

`ifdef EEPROM_RESPONDER_WRITE_PROTECT_EN
    logic w_unused_wp_rise, w_unused_wp_fall;

    bus_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wp_sync (
        .i_clk(sys_clk), .i_rst(rst), .i_async(bus.wp_in),
        .o_level(w_wp_lvl), .o_rise(w_unused_wp_rise), .o_fall(w_unused_wp_fall));
`else
    assign w_wp_lvl = 1'b0;
`endif

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [HDR-2:0]         r_shift;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_out;
    logic                   r_miso, r_err, r_frame_done, r_cmd_err;
    logic [ADDR_BITS-1:0]   r_last_addr;
    logic [DATA_BITS-1:0]   r_mem [2**ADDR_BITS];

    // Shift register is one bit short: the incoming bit completes the header in the decode cycle.
    logic [HDR-1:0]         w_shift_nxt;
    logic [OPCODE_BITS-1:0] w_hdr_op;
    logic [ADDR_BITS-1:0]   w_hdr_addr;
    logic                   w_clear, w_shift, w_decode, w_load_rd, w_mem_we;
    logic                   w_miso_drive, w_miso_clr, w_err_set, w_done;

    assign w_shift_nxt = {r_shift, w_mosi_lvl};
    assign w_hdr_op    = w_shift_nxt[HDR-1 -: OPCODE_BITS];
    assign w_hdr_addr  = w_shift_nxt[ADDR_BITS-1:0];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_decode     = 1'b0;
        w_load_rd    = 1'b0;
        w_mem_we     = 1'b0;
        w_miso_drive = 1'b0;
        w_miso_clr   = 1'b0;
        w_err_set    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: if (w_ss_rise) begin
                w_clear     = 1'b1;
                w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == HDR_LAST) begin
                        w_decode = 1'b1;
                        if (w_hdr_op == L_OP_READ) begin
                            w_load_rd   = 1'b1;
                            w_state_nxt = ST_RD_DATA;
                        end else if (w_hdr_op == L_OP_WRITE) begin
                            w_state_nxt = ST_WR_DATA;
                        end else begin
                            w_err_set   = 1'b1;
                            w_state_nxt = ST_WAIT_SS;
                        end
                    end
                end
            end
            ST_RD_DATA: begin
                if (w_ss_fall) begin
                    w_miso_clr  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == FRAME_LAST) begin
                        w_miso_clr  = 1'b1;
                        w_state_nxt = ST_WAIT_SS;
                    end
                end else if (w_sclk_fall) begin
                    w_miso_drive = 1'b1;
                end
            end
            ST_WR_DATA: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == FRAME_LAST) begin
                        w_mem_we    = ~w_wp_lvl;
                        w_err_set   = w_wp_lvl;
                        w_state_nxt = ST_WAIT_SS;
                    end
                end
            end
            ST_WAIT_SS: if (w_ss_fall) begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_out        <= '0;
            r_miso       <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            if (w_clear) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_err     <= 1'b0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_shift   <= w_shift_nxt[HDR-2:0];
            end
            if (w_decode)  r_addr <= w_hdr_addr;
            if (w_err_set) r_err  <= 1'b1;
            if (w_load_rd) begin
                r_out <= r_mem[w_hdr_addr];
            end else if (w_miso_drive) begin
                r_out <= {r_out[DATA_BITS-2:0], 1'b0};
            end
            if (w_miso_clr)        r_miso <= 1'b0;
            else if (w_miso_drive) r_miso <= r_out[DATA_BITS-1];
            r_frame_done <= w_done;
            r_cmd_err    <= w_done & r_err;
            if (w_done) r_last_addr <= r_addr;
        end
    end

    // Storage is deliberately outside reset so contents survive a mid-frame reset.
    always_ff @(posedge sys_clk) begin
        if (w_mem_we) r_mem[r_addr] <= w_shift_nxt[DATA_BITS-1:0];
    end

    assign bus.miso_out   = r_miso;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.cmd_err    = r_cmd_err;
    assign bus.last_addr  = r_last_addr;

endmodule

// File: tb/tb_eeprom_responder.sv
// Bench for eeprom_responder: table of frames with a scoreboard queue, plus mid-read reset
// and, with EEPROM_RESPONDER_WRITE_PROTECT_EN defined, a protected write.
module tb_eeprom_responder;
    import eeprom_bus_pkg::*;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    eeprom_responder_if #(.ADDR_BITS(9)) bus ();

    eeprom_responder #(.OPCODE_BITS(3), .ADDR_BITS(9), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [8:0] addr;
        logic [7:0] data;
        int         nbits;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_rd;
        logic [8:0] exp_last;
    } vec_t;

    typedef struct {
        string      name;
        int         done;
        int         err;
        logic [7:0] rd;
        logic [8:0] last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   done_total = 0;
    int   err_total  = 0;
    exp_t sb[$];
    vec_t vecs[16];

    always @(negedge sys_clk) begin
        if (bus.frame_done) done_total <= done_total + 1;
        if (bus.cmd_err)    err_total  <= err_total + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] op, input logic [8:0] a,
                                input logic [7:0] d, input int nb, input int dn, input int er,
                                input logic [7:0] rd, input logic [8:0] last);
        vec_t v;
        v.name = n; v.op = op; v.addr = a; v.data = d; v.nbits = nb;
        v.exp_done = dn; v.exp_err = er; v.exp_rd = rd; v.exp_last = last;
        return v;
    endfunction

    // MISO is sampled just before each SCLK rise; sample i lands in miso_seq[19-i].
    task automatic run_frame(input logic [2:0] op, input logic [8:0] addr, input logic [7:0] data,
                             input int nbits, output logic [19:0] miso_seq, output logic busy_mid,
                             output int dn, output int er);
        logic [19:0] fr;
        int d0, e0;
        fr = {op, addr, data};
        d0 = done_total;
        e0 = err_total;
        miso_seq = '0;
        busy_mid = 1'b0;
        bus.ss_in = 1'b1;
        wait_cyc(8);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi_in = fr[19-i];
            wait_cyc(4);
            miso_seq[19-i] = bus.miso_out;
            bus.sclk_in = 1'b1;
            wait_cyc(8);
            if (i == 0) busy_mid = bus.busy;
            bus.sclk_in = 1'b0;
            wait_cyc(4);
        end
        wait_cyc(8);
        bus.ss_in   = 1'b0;
        bus.mosi_in = 1'b0;
        wait_cyc(12);
        dn = done_total - d0;
        er = err_total - e0;
    endtask

    task automatic frame_and_score(input vec_t v);
        exp_t e, got;
        logic [19:0] ms;
        logic bm;
        int dn, er;
        e.name = v.name; e.done = v.exp_done; e.err = v.exp_err; e.rd = v.exp_rd; e.last = v.exp_last;
        sb.push_back(e);
        run_frame(v.op, v.addr, v.data, v.nbits, ms, bm, dn, er);
        if (sb.size() == 0) begin
            check({v.name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({got.name, " frame_done"}, dn, got.done);
            check({got.name, " cmd_err"}, er, got.err);
            check({got.name, " read byte"}, {24'd0, ms[7:0]}, {24'd0, got.rd});
            check({got.name, " miso header"}, {20'd0, ms[19:8]}, 32'd0);
            check({got.name, " last_addr"}, {23'd0, bus.last_addr}, {23'd0, got.last});
            check({got.name, " busy mid"}, {31'd0, bm}, 32'd1);
            check({got.name, " busy end"}, {31'd0, bus.busy}, 32'd0);
            check({got.name, " miso idle"}, {31'd0, bus.miso_out}, 32'd0);
        end
    endtask

    initial begin
        logic [19:0] fr;
        int d0;

        vecs[0]  = mk("wr037",    3'b101, 9'h037, 8'h6d, 20, 1, 0, 8'h00, 9'h037);
        vecs[1]  = mk("rd037",    3'b110, 9'h037, 8'h00, 20, 1, 0, 8'h6d, 9'h037);
        vecs[2]  = mk("wr1ff",    3'b101, 9'h1ff, 8'ha3, 20, 1, 0, 8'h00, 9'h1ff);
        vecs[3]  = mk("wr000",    3'b101, 9'h000, 8'hb5, 20, 1, 0, 8'h00, 9'h000);
        vecs[4]  = mk("rd1ff",    3'b110, 9'h1ff, 8'h00, 20, 1, 0, 8'ha3, 9'h1ff);
        vecs[5]  = mk("rd000",    3'b110, 9'h000, 8'h00, 20, 1, 0, 8'hb5, 9'h000);
        vecs[6]  = mk("wr09a",    3'b101, 9'h09a, 8'h42, 20, 1, 0, 8'h00, 9'h09a);
        vecs[7]  = mk("badop111", 3'b111, 9'h09a, 8'hff, 20, 1, 1, 8'h00, 9'h09a);
        vecs[8]  = mk("rd09a",    3'b110, 9'h09a, 8'h00, 20, 1, 0, 8'h42, 9'h09a);
        vecs[9]  = mk("wr120",    3'b101, 9'h120, 8'h99, 20, 1, 0, 8'h00, 9'h120);
        vecs[10] = mk("rd000b",   3'b110, 9'h000, 8'h00, 20, 1, 0, 8'hb5, 9'h000);
        vecs[11] = mk("abort120", 3'b101, 9'h120, 8'h55, 15, 0, 0, 8'h00, 9'h000);
        vecs[12] = mk("rd120",    3'b110, 9'h120, 8'h00, 20, 1, 0, 8'h99, 9'h120);
        vecs[13] = mk("badop000", 3'b000, 9'h005, 8'h00, 20, 1, 1, 8'h00, 9'h005);
        vecs[14] = mk("wr010",    3'b101, 9'h010, 8'h5a, 20, 1, 0, 8'h00, 9'h010);
        vecs[15] = mk("rd010",    3'b110, 9'h010, 8'h00, 20, 1, 0, 8'h5a, 9'h010);

        bus.ss_in = 1'b0; bus.sclk_in = 1'b0; bus.mosi_in = 1'b0;
`ifdef EEPROM_RESPONDER_WRITE_PROTECT_EN
        bus.wp_in = 1'b0;
`endif
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(5);
        check("reset miso", {31'd0, bus.miso_out}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("reset cmd_err", {31'd0, bus.cmd_err}, 32'd0);
        check("reset last_addr", {23'd0, bus.last_addr}, 32'd0);

        for (int i = 0; i < 16; i++) frame_and_score(vecs[i]);

        // Reset after the 14th rise of a read of 0x010 (holds 0x5a, bit6 = 1 on MISO).
        fr = {3'b110, 9'h010, 8'h00};
        d0 = done_total;
        bus.ss_in = 1'b1;
        wait_cyc(8);
        for (int i = 0; i < 14; i++) begin
            bus.mosi_in = fr[19-i];
            wait_cyc(4);
            bus.sclk_in = 1'b1;
            wait_cyc(8);
            if (i < 13) begin
                bus.sclk_in = 1'b0;
                wait_cyc(4);
            end
        end
        check("pre-reset miso", {31'd0, bus.miso_out}, 32'd1);
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        wait_cyc(1);
        check("in-reset miso", {31'd0, bus.miso_out}, 32'd0);
        check("in-reset busy", {31'd0, bus.busy}, 32'd0);
        check("in-reset last_addr", {23'd0, bus.last_addr}, 32'd0);
        bus.ss_in = 1'b0; bus.sclk_in = 1'b0; bus.mosi_in = 1'b0;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(10);
        check("post-reset busy", {31'd0, bus.busy}, 32'd0);
        check("post-reset no frame_done", done_total - d0, 32'd0);
        frame_and_score(mk("rd010 after reset", 3'b110, 9'h010, 8'h00, 20, 1, 0, 8'h5a, 9'h010));

`ifdef EEPROM_RESPONDER_WRITE_PROTECT_EN
        bus.wp_in = 1'b1;
        wait_cyc(4);
        frame_and_score(mk("wp wr010", 3'b101, 9'h010, 8'h3c, 20, 1, 1, 8'h00, 9'h010));
        bus.wp_in = 1'b0;
        wait_cyc(4);
        frame_and_score(mk("wp rd010", 3'b110, 9'h010, 8'h00, 20, 1, 0, 8'h5a, 9'h010));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
